jk_counter_seq: RTL and testbench
=================================

// Module: jk_counter_seq
// PURPOSE
//  Command-driven sequencer for a WIDTH-bit register built from jk_ff cells.
//  Accepts one command at a time: clear, set, load, count up/down, invert N times.
//  Drives every cell's J/K each step; q is the register content.
//  Sits between lab control logic (switches/FSM) and the jk_ff bank.
// PARAMETERS
//  WIDTH  4  register width = number of jk_ff instances
//  LEN_W  8  width of cmd_len (step count per command)
// PORTS
//  clk        in   1       clock; all state (FSM and jk_ff cells) updates on the falling edge
//  reset      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       = (state==IDLE) & reset; command accepted on a falling edge with valid&ready
//  cmd_op     in   3       op code, jk_seq_pkg::op_e
//  cmd_data   in   WIDTH   load value (OP_LOAD only)
//  cmd_len    in   LEN_W   step count (OP_UP/OP_DOWN/OP_INV only)
//  q          out  WIDTH   register content
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse in DONE
//  wrap       out  1       sticky for the current command: any step wrapped; cleared on accept
// BEHAVIOUR
//  Reset (async, any state): q=0, state=IDLE, busy=0, done=0, wrap=0, cmd_ready=0 while reset=0.
//   A reset during RUN aborts the command; no done pulse is produced.
//  FSM IDLE->RUN->DONE->IDLE. Every transition is on a falling clk edge.
//   IDLE: on accept, latch op/data into op_r/data_r and set rem=eff_len; clear wrap.
//     Go to RUN if eff_len!=0, else go to DONE.
//   RUN: each edge applies one step to q; rem--. When rem==1 at the edge, go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in RUN and DONE.
//  eff_len: 1 for OP_NOP/OP_CLR/OP_SET/OP_LOAD; cmd_len for the others (0 = no step).
//  Latency: accept at edge E0. q holds the k-th step result after edge Ek.
//   done is high between E(n) and E(n+1); cmd_ready is back to 1 after E(n+1).
//  J/K generation, combinational from op_r, data_r and q, forced to 0 outside RUN:
//   NOP   j=0, k=0 (hold)
//   CLR   j=0, k=1
//   SET   j=1, k=0
//   LOAD  j=data_r, k=~data_r
//   UP    j[i]=k[i]=&q[i-1:0] (bit0: 1)
//   DOWN  j[i]=k[i]=&~q[i-1:0] (bit0: 1)
//   INV   j=k='1
//  Arithmetic is mod 2^WIDTH.
//  wrap is set on any UP step taken from all-ones, or any DOWN step taken from zero.
//  cmd_valid while busy is ignored; nothing is queued.
//  Undefined op codes execute as NOP.
// STRUCTURE
//  jk_seq_pkg: typedef enum logic[2:0] op_e
//   {OP_NOP,OP_CLR,OP_SET,OP_LOAD,OP_UP,OP_DOWN,OP_INV}.
//  jk_seq_pkg: typedef enum state_e {IDLE,RUN,DONE}.
//  jk_seq_pkg: function jk_step(op,data,q) returning the {j,k} vectors.
//  Sub-module: generate loop of WIDTH existing jk_ff instances sharing clk/reset.
//   The controller never writes q directly.
// TESTING (WIDTH=4, LEN_W=8)
//  1 reset; LOAD data=4'hA -> q=A after E1, done pulse in next cycle, wrap=0.
//  2 LOAD E; UP len=3 -> q E,F,0,1 on E1..E3; wrap=1; done 1 cycle; busy 0 after.
//  3 CLR; DOWN len=1 -> q=F, wrap=1.
//    Then SET -> q=F, wrap=0 (cleared on accept).
//  4 LOAD 5; INV len=2 -> q A then 5.
//    UP len=0 -> done next cycle, q unchanged, wrap=0.
//  5 cmd_valid held with a different op during RUN -> ignored.
//    q matches the first command only; cmd_ready=0 until after DONE.
//  6 reset low mid UP len=10 -> q=0, busy=0, done=0 immediately.
//    After release, LOAD 3 is accepted and gives q=3.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and the per-cell J/K rule for the jk_ff command sequencer.
// jk_step works on one cell; callers supply the prefix flags of the lower bits.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_SET  = 3'd2,
    OP_LOAD = 3'd3,
    OP_UP   = 3'd4,
    OP_DOWN = 3'd5,
    OP_INV  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // lo_ones / lo_zeros: all lower bits of q are 1 / 0 (both 1 for bit 0).
  function automatic jk_t jk_step(input logic [2:0] op, input logic d,
                                  input logic lo_ones, input logic lo_zeros);
    jk_t r;
    r.j = 1'b0;
    r.k = 1'b0;
    case (op)
      OP_CLR:  r.k = 1'b1;
      OP_SET:  r.j = 1'b1;
      OP_LOAD: begin
        r.j = d;
        r.k = ~d;
      end
      OP_UP: begin
        r.j = lo_ones;
        r.k = lo_ones;
      end
      OP_DOWN: begin
        r.j = lo_zeros;
        r.k = lo_zeros;
      end
      OP_INV: begin
        r.j = 1'b1;
        r.k = 1'b1;
      end
      default: begin
        r.j = 1'b0;
        r.k = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_counter_seq_bank.sv
// Bank of WIDTH jk_ff cells sharing clock and reset; q is the register content.
module jk_counter_seq_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop cell, falling-edge clocked, asynchronous active-low reset.
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_seq.sv
// Command sequencer: drives J/K of a jk_ff bank one step per falling edge.
// The register itself lives only in the bank; this controller never writes q.
module jk_counter_seq
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_r, state_d;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] rem_r;
  logic             wrap_r;
  logic [LEN_W-1:0] eff_len;
  logic             accept;
  logic             step_wraps;
  logic [WIDTH-1:0] ones_pre, zeros_pre;
  logic [WIDTH-1:0] j_v, k_v;
  jk_t              jk_bit;

  assign cmd_ready = (state_r == IDLE) & reset;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign wrap      = wrap_r;

  // Single-step ops take exactly one step; undefined codes fall here as NOP.
  always_comb begin
    eff_len = LEN_W'(1);
    case (cmd_op)
      OP_UP, OP_DOWN, OP_INV: eff_len = cmd_len;
      default:                eff_len = LEN_W'(1);
    endcase
  end

  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: if (accept) state_d = (eff_len != '0) ? RUN : DONE;
      RUN:  if (rem_r == LEN_W'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  assign step_wraps = ((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && ~(|q));

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      rem_r  <= '0;
      wrap_r <= 1'b0;
    end else if (accept) begin
      rem_r  <= eff_len;
      wrap_r <= 1'b0;
    end else if (state_r == RUN) begin
      rem_r <= rem_r - LEN_W'(1);
      if (step_wraps) wrap_r <= 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (accept) begin
      op_r   <= cmd_op;
      data_r <= cmd_data;
    end
  end

  // Carry/borrow chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    ones_pre     = '0;
    zeros_pre    = '0;
    ones_pre[0]  = 1'b1;
    zeros_pre[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      ones_pre[i]  = ones_pre[i-1] & q[i-1];
      zeros_pre[i] = zeros_pre[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    j_v    = '0;
    k_v    = '0;
    jk_bit = '0;
    if (state_r == RUN) begin
      for (int i = 0; i < WIDTH; i++) begin
        jk_bit = jk_step(op_r, data_r[i], ones_pre[i], zeros_pre[i]);
        j_v[i] = jk_bit.j;
        k_v[i] = jk_bit.k;
      end
    end
  end

  jk_counter_seq_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .j     (j_v),
    .k     (k_v),
    .q     (q)
  );

endmodule

// File: tb/tb_jk_counter_seq.sv
// Randomized and directed bench for jk_counter_seq against an arithmetic register model.
module tb_jk_counter_seq;
  import jk_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [WIDTH-1:0] q;
  logic             busy, done, wrap;

  int n_chk = 0;
  int n_err = 0;
  int mq = 0;
  int mwrap = 0;

  always #5 clk = ~clk;

  jk_counter_seq #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_next(input int op, input int d, input int qv);
    case (op)
      1: return 0;
      2: return MASK;
      3: return d & MASK;
      4: return (qv + 1) % (MASK + 1);
      5: return (qv + MASK) % (MASK + 1);
      6: return qv ^ MASK;
      default: return qv;
    endcase
  endfunction

  function automatic int ref_len(input int op, input int len);
    return (op >= 4 && op <= 6) ? len : 1;
  endfunction

  // Called at a rising edge with the DUT idle; returns at a rising edge.
  task automatic run_cmd(input int op, input int d, input int len, input bit hold);
    int n;
    n = ref_len(op, len);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = WIDTH'(d);
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    @(posedge clk);
    mwrap = 0;
    if (hold) begin
      cmd_op   = 3'((op + 1) % 8);
      cmd_data = ~cmd_data;
      cmd_len  = LEN_W'(3);
    end else begin
      cmd_valid = 1'b0;
    end
    check("ready_after_accept", cmd_ready, 0);
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, (n == 0));
    check("wrap_cleared", wrap, 0);
    for (int s = 1; s <= n; s++) begin
      if ((op == 4 && mq == MASK) || (op == 5 && mq == 0)) mwrap = 1;
      mq = ref_next(op, d, mq);
      @(negedge clk);
      @(posedge clk);
      check("q_step", q, mq);
      check("wrap_step", wrap, mwrap);
      check("done_step", done, (s == n));
      check("busy_step", busy, 1);
      check("ready_step", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    check("done_end", done, 0);
    check("busy_end", busy, 0);
    check("ready_end", cmd_ready, 1);
    check("q_end", q, mq);
    check("wrap_end", wrap, mwrap);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_wrap", wrap, 0);
    reset = 1'b1;
    @(posedge clk);
    check("ready_idle", cmd_ready, 1);

    run_cmd(3, 4'hA, 0, 1'b0);
    run_cmd(3, 4'hE, 0, 1'b0);
    run_cmd(4, 0, 3, 1'b0);
    run_cmd(1, 0, 0, 1'b0);
    run_cmd(5, 0, 1, 1'b0);
    run_cmd(2, 0, 0, 1'b0);
    run_cmd(3, 4'h5, 0, 1'b0);
    run_cmd(6, 0, 2, 1'b0);
    run_cmd(4, 0, 0, 1'b0);
    run_cmd(4, 0, 5, 1'b1);
    run_cmd(7, 4'h3, 9, 1'b0);

    // Abort an in-flight UP with an asynchronous reset
    cmd_valid = 1'b1;
    cmd_op    = 3'(4);
    cmd_len   = LEN_W'(10);
    @(negedge clk);
    @(posedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_wrap", wrap, 0);
    repeat (2) @(posedge clk);
    check("abort_no_done", done, 0);
    reset = 1'b1;
    mq = 0;
    @(posedge clk);
    run_cmd(3, 4'h3, 0, 1'b0);

    for (int c = 0; c < 80; c++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
              int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
